vdic_mult_responder: RTL and testbench

- Responder end of the team's req/ack parity-protected signed multiplier interface.
- Accepts two signed DATA_W-bit operands, each with an even-parity bit, when req is high, and acknowledges them with ack.
- Computes the signed product iteratively, or flags an argument parity error.
- Returns the result with its even-parity bit on a one-cycle result_rdy strobe. Sits behind any initiator (bench driver or upstream controller) speaking this protocol.

---
 rtl/vdic_mult_pkg.sv | 22 ++
 rtl/vdic_mult_seq_core.sv | 71 +++++++
 rtl/vdic_mult_responder.sv | 130 +++++++++++++
 tb/tb_vdic_mult_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vdic_mult_pkg.sv
// Shared types and helpers for the parity-protected signed multiplier responder.
// Ports: none. This package holds the default operand width, the FSM state type and
//        the even-parity helper that both the design and its bench use.
package vdic_mult_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_RES_W  = 2 * DEF_DATA_W;
  // The parity helper takes a fixed wide vector. Callers zero-extend into it, which
  // leaves the XOR unchanged for any operand or result width up to 64 bits.
  localparam int PAR_W      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic logic parity(input logic [PAR_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/vdic_mult_seq_core.sv
// Iterative signed multiplier: shift-add on the operand magnitudes, with the sign
// applied at the end. It does exactly DATA_W iterations after start.
// Ports: clk, rst (sync, active-high), start/a/b load the operands; done pulses for one
//        cycle while product already shows the final value, so a caller can register it
//        on that same edge.
module vdic_mult_seq_core #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic                  busy;
  logic [CNT_W-1:0]      count;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [2*DATA_W-1:0]   acc;
  logic                  neg;

  logic [DATA_W-1:0]     a_mag;
  logic [DATA_W-1:0]     b_mag;
  logic [2*DATA_W-1:0]   acc_nxt;

  // The magnitude of the most negative value still fits in DATA_W unsigned bits.
  assign a_mag = a[DATA_W-1] ? -a : a;
  assign b_mag = b[DATA_W-1] ? -b : b;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // done is decoded from the last iteration, and product comes straight from that
  // iteration's sum, so no extra cycle is needed to hand the result over.
  assign done    = busy && (count == LAST);
  assign product = neg ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      mcand  <= {{DATA_W{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      neg    <= a[DATA_W-1] ^ b[DATA_W-1];
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vdic_mult_responder.sv
// Responder for the req/ack parity-protected signed multiplier interface.
// Ports: clk, rst (sync, active-high); arg_a/arg_b each come with an even-parity bit
//        and are qualified by req; ack pulses when the operands are captured; result,
//        result_parity and arg_parity_error are valid on the result_rdy pulse and hold
//        their values until the next pulse.
// Build option: define VDIC_MULT_FAST_EN to replace the DATA_W-cycle iterative core with
//               a single-cycle multiply. The protocol is the same in both builds.
module vdic_mult_responder
  import vdic_mult_pkg::*;
#(
  parameter int DATA_W = vdic_mult_pkg::DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     arg_a,
  input  logic                  arg_a_parity,
  input  logic [DATA_W-1:0]     arg_b,
  input  logic                  arg_b_parity,
  input  logic                  req,
  output logic                  ack,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_parity,
  output logic                  result_rdy,
  output logic                  arg_parity_error
);

  localparam int PROD_W = 2 * DATA_W;

  state_t              state, state_nxt;
  logic                ack_nxt, rdy_nxt, perr_nxt, rpar_nxt;
  logic [PROD_W-1:0]   result_nxt;
  logic                start;
  logic                args_ok;
  logic                calc_done;
  logic [PROD_W-1:0]   calc_res;

  assign args_ok = (parity(PAR_W'(arg_a)) == arg_a_parity) &&
                   (parity(PAR_W'(arg_b)) == arg_b_parity);

`ifdef VDIC_MULT_FAST_EN
  logic [DATA_W-1:0] op_a, op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (start) begin
      op_a <= arg_a;
      op_b <= arg_b;
    end
  end

  assign calc_done = 1'b1;
  assign calc_res  = $signed(op_a) * $signed(op_b);
`else
  // The core loads on the capture edge, so its DATA_W iterations end on the edge
  // that also registers the result.
  vdic_mult_seq_core #(.DATA_W(DATA_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (arg_a),
    .b       (arg_b),
    .done    (calc_done),
    .product (calc_res)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    ack_nxt    = 1'b0;
    rdy_nxt    = 1'b0;
    result_nxt = result;
    rpar_nxt   = result_parity;
    perr_nxt   = arg_parity_error;
    case (state)
      IDLE: begin
        if (req) begin
          ack_nxt = 1'b1;
          if (args_ok) begin
            start     = 1'b1;
            state_nxt = CALC;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      ERR: begin
        result_nxt = '0;
        rpar_nxt   = 1'b0;
        perr_nxt   = 1'b1;
        rdy_nxt    = 1'b1;
        state_nxt  = IDLE;
      end
      CALC: begin
        if (calc_done) begin
          result_nxt = calc_res;
          rpar_nxt   = parity(PAR_W'(calc_res));
          perr_nxt   = 1'b0;
          rdy_nxt    = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
    end else begin
      ack              <= ack_nxt;
      result           <= result_nxt;
      result_parity    <= rpar_nxt;
      result_rdy       <= rdy_nxt;
      arg_parity_error <= perr_nxt;
    end
  end

endmodule

// File: tb/tb_vdic_mult_responder.sv
// Directed and random bench for vdic_mult_responder.
// Ports: none. It drives the responder through the req/ack protocol and checks ack,
//        latency, result, result_parity and arg_parity_error against expected values.
module tb_vdic_mult_responder;
  import vdic_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] arg_a, arg_b;
  logic        arg_a_parity, arg_b_parity;
  logic        req;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] held_res = '0;

`ifdef VDIC_MULT_FAST_EN
  localparam int CALC_LAT = 1;
`else
  localparam int CALC_LAT = 16;
`endif

  always #5 clk = ~clk;

  vdic_mult_responder #(.DATA_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .req              (req),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs are sampled at negedge. The operation is captured on
  // the following posedge. When the result arrives, hold keeps req high so that the next
  // IDLE cycle starts a new operation.
  task automatic do_op(input string tag, input logic [15:0] a, input logic ap,
                       input logic [15:0] b, input logic bp, input bit hold,
                       input logic [31:0] exp_res, input logic exp_par, input logic exp_err);
    int  lat;
    bit  seen;
    arg_a = a; arg_a_parity = ap;
    arg_b = b; arg_b_parity = bp;
    req = 1'b1;
    @(negedge clk);
    chk({tag, " ack"}, 32'(ack), 32'd1);
    chk({tag, " no rdy with ack"}, 32'(result_rdy), 32'd0);
    chk({tag, " previous result held"}, result, held_res);
    // Changing the operands after ack must not affect the result.
    arg_a = 16'($urandom);
    arg_b = 16'($urandom);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (result_rdy) seen = 1'b1;
    end
    chk({tag, " rdy seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), exp_err ? 32'd1 : 32'(CALC_LAT));
    chk({tag, " ack low at rdy"}, 32'(ack), 32'd0);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " parity"}, 32'(result_parity), 32'(exp_par));
    chk({tag, " perr"}, 32'(arg_parity_error), 32'(exp_err));
    held_res = exp_res;
    if (!hold) begin
      req = 1'b0;
      @(negedge clk);
      chk({tag, " rdy one cycle"}, 32'(result_rdy), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rap, rbp, rerr;
    logic signed [31:0] rprod;
    logic [15:0] extremes [5];
    int          rdy_count;

    extremes[0] = 16'h8000; extremes[1] = 16'h7FFF; extremes[2] = 16'h0000;
    extremes[3] = 16'hFFFF; extremes[4] = 16'h0001;

    rst = 1'b1; req = 1'b0;
    arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset rdy", 32'(result_rdy), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset parity", 32'(result_parity), 32'd0);
    chk("reset perr", 32'(arg_parity_error), 32'd0);
    @(negedge clk);
    chk("idle no ack", 32'(ack), 32'd0);

    // 3 * -5 = -15. 0xFFFFFFF1 has 29 ones, so its even-parity bit is 1.
    do_op("basic", 16'h0003, 1'b0, 16'hFFFB, 1'b1, 1'b0, 32'hFFFF_FFF1, 1'b1, 1'b0);
    do_op("min*min", 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0, 32'h4000_0000, 1'b1, 1'b0);
    do_op("max*min", 16'h7FFF, 1'b1, 16'h8000, 1'b1, 1'b0, 32'hC000_8000, 1'b1, 1'b0);
    do_op("zero*max", 16'h0000, 1'b0, 16'h7FFF, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
    do_op("neg*neg", 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 1'b0);
    do_op("bad a parity", 16'h0001, 1'b0, 16'h0002, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    do_op("bad b parity", 16'h0003, 1'b0, 16'h0005, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    // Back-to-back: req stays high across result_rdy.
    do_op("b2b first", 16'h0005, 1'b0, 16'h0007, 1'b1, 1'b1, 32'd35, 1'b1, 1'b0);
    do_op("b2b second", 16'h0002, 1'b1, 16'h0003, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0);

    // Reset while the multiply is still running.
    arg_a = 16'h0009; arg_a_parity = 1'b0; arg_b = 16'h000B; arg_b_parity = 1'b1;
    req = 1'b1;
    @(negedge clk);
    chk("rstmid ack", 32'(ack), 32'd1);
    req = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid rdy", 32'(result_rdy), 32'd0);
    chk("rstmid result", result, 32'd0);
    chk("rstmid parity", 32'(result_parity), 32'd0);
    chk("rstmid perr", 32'(arg_parity_error), 32'd0);
    chk("rstmid ack low", 32'(ack), 32'd0);
    rdy_count = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_rdy) rdy_count++;
    end
    chk("rstmid no late rdy", 32'(rdy_count), 32'd0);
    held_res = '0;
    do_op("after reset", 16'h0009, 1'b0, 16'h000B, 1'b1, 1'b0, 32'd99, 1'b0, 1'b0);

    // Random operations.
    for (int i = 0; i < 1000; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? extremes[$urandom_range(0, 4)] : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? extremes[$urandom_range(0, 4)] : 16'($urandom);
      rap = (^ra) ^ ($urandom_range(0, 7) == 0);
      rbp = (^rb) ^ ($urandom_range(0, 7) == 0);
      rerr = (rap != ^ra) || (rbp != ^rb);
      rprod = $signed(ra) * $signed(rb);
      if (rerr) rprod = '0;
      do_op("random", ra, rap, rb, rbp, 1'b0, rprod, ^rprod, rerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
